data_mem_ctrl: RTL and testbench

- Load/store controller directly downstream of the single-cycle datapath.
- Consumes the ALU address, store data and memory control from the datapath, and runs a req/ack handshake with an external data-memory bus.
- Returns load data on the datapath's mem_rdata input.
- Asserts stall so the PC and register-file write are held until the bus access completes.

---
 rtl/dmem_pkg.sv | 18 +
 rtl/dmem_timeout_cnt.sv | 32 +++
 rtl/data_mem_ctrl.sv | 153 +++++++++++++++
 tb/tb_data_mem_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory load/store controller:
// state encoding, default bus timeout and the word-alignment mask.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } dmem_state_t;

  localparam int          TIMEOUT_DEFAULT = 255;
  localparam logic [1:0]  ALIGN_MASK      = 2'b11;

  function automatic logic is_aligned(input logic [1:0] i_lsb);
    return ((i_lsb & ALIGN_MASK) == 2'b00);
  endfunction

endpackage

// File: rtl/dmem_timeout_cnt.sv
// 8-bit bus-wait counter with clear/enable; o_tc flags the last cycle
// the controller is allowed to wait for an acknowledge.
module dmem_timeout_cnt #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  localparam logic [7:0] TC_VAL = 8'(TIMEOUT - 1);

  logic [7:0] r_count;

  // wait counter; clear wins over enable
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= 8'd0;
    end else if (i_clr) begin
      r_count <= 8'd0;
    end else if (i_en) begin
      r_count <= r_count + 8'd1;
    end else begin
      r_count <= r_count;
    end
  end

  assign o_tc = (r_count == TC_VAL);

endmodule

// File: rtl/data_mem_ctrl.sv
// Load/store controller between the single-cycle datapath and a req/ack
// data-memory bus; stalls the datapath while a bus access is in flight.
module data_mem_ctrl
  import dmem_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              memread,
  input  logic              memwrite,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              stall,
  output logic              addr_err,
  output logic              bus_err,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_ack,
  input  logic [DATA_W-1:0] bus_rdata
);

  dmem_state_t       r_state;
  dmem_state_t       w_state_nxt;
  logic              r_bus_req;
  logic              r_bus_we;
  logic [ADDR_W-1:0] r_bus_addr;
  logic [DATA_W-1:0] r_bus_wdata;
  logic [DATA_W-1:0] r_mem_rdata;
  logic              r_addr_err;
  logic              r_bus_err;

  logic              w_bus_req_nxt;
  logic              w_bus_we_nxt;
  logic [ADDR_W-1:0] w_bus_addr_nxt;
  logic [DATA_W-1:0] w_bus_wdata_nxt;
  logic [DATA_W-1:0] w_mem_rdata_nxt;
  logic              w_addr_err_nxt;
  logic              w_bus_err_nxt;
  logic              w_cnt_clr;
  logic              w_cnt_en;
  logic              w_cnt_tc;
  logic              w_access;
  logic              w_aligned;

  assign w_access  = memread | memwrite;
  assign w_aligned = is_aligned(addr[1:0]);

  dmem_timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout_cnt (
    .clk   (clk),
    .rst   (rst),
    .i_clr (w_cnt_clr),
    .i_en  (w_cnt_en),
    .o_tc  (w_cnt_tc)
  );

  // next-state and next-output decode
  always_comb begin
    w_state_nxt     = r_state;
    w_bus_req_nxt   = r_bus_req;
    w_bus_we_nxt    = r_bus_we;
    w_bus_addr_nxt  = r_bus_addr;
    w_bus_wdata_nxt = r_bus_wdata;
    w_mem_rdata_nxt = r_mem_rdata;
    w_addr_err_nxt  = 1'b0;
    w_bus_err_nxt   = 1'b0;
    w_cnt_clr       = 1'b0;
    w_cnt_en        = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_access && w_aligned) begin
          w_bus_addr_nxt  = addr;
          w_bus_wdata_nxt = wdata;
          w_bus_we_nxt    = memwrite;
          w_bus_req_nxt   = 1'b1;
          w_cnt_clr       = 1'b1;
          w_state_nxt     = REQ;
        end else if (w_access) begin
          w_addr_err_nxt  = 1'b1;
          w_mem_rdata_nxt = '0;
        end else begin
          w_state_nxt     = IDLE;
        end
      end
      REQ: begin
        // an acknowledge on the final allowed cycle still completes normally
        if (bus_ack) begin
          w_bus_req_nxt = 1'b0;
          if (!r_bus_we) begin
            w_mem_rdata_nxt = bus_rdata;
          end else begin
            w_mem_rdata_nxt = r_mem_rdata;
          end
          w_state_nxt = DONE;
        end else if (w_cnt_tc) begin
          w_bus_req_nxt   = 1'b0;
          w_mem_rdata_nxt = '0;
          w_bus_err_nxt   = 1'b1;
          w_state_nxt     = DONE;
        end else begin
          w_cnt_en = 1'b1;
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt   = IDLE;
        w_bus_req_nxt = 1'b0;
      end
    endcase
  end

  // state and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_bus_req   <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_addr  <= '0;
      r_bus_wdata <= '0;
      r_mem_rdata <= '0;
      r_addr_err  <= 1'b0;
      r_bus_err   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_bus_req   <= w_bus_req_nxt;
      r_bus_we    <= w_bus_we_nxt;
      r_bus_addr  <= w_bus_addr_nxt;
      r_bus_wdata <= w_bus_wdata_nxt;
      r_mem_rdata <= w_mem_rdata_nxt;
      r_addr_err  <= w_addr_err_nxt;
      r_bus_err   <= w_bus_err_nxt;
    end
  end

  assign stall     = ((r_state == IDLE) && w_access && w_aligned) || (r_state == REQ);
  assign mem_rdata = r_mem_rdata;
  assign addr_err  = r_addr_err;
  assign bus_err   = r_bus_err;
  assign bus_req   = r_bus_req;
  assign bus_we    = r_bus_we;
  assign bus_addr  = r_bus_addr;
  assign bus_wdata = r_bus_wdata;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Scoreboard bench for data_mem_ctrl: directed accesses push expected
// completions; a negedge monitor pops and compares each completion.
module tb_data_mem_ctrl;

  logic        clk;
  logic        rst;
  logic        memread;
  logic        memwrite;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] mem_rdata;
  logic        stall;
  logic        addr_err;
  logic        bus_err;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  typedef struct {
    logic        is_aerr;
    logic        is_berr;
    logic [31:0] rdata;
    int          stall_n;
    int          req_n;
    logic        we;
    logic [31:0] baddr;
    logic [31:0] bwdata;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks;
  int   n_errors;

  data_mem_ctrl #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .TIMEOUT (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .memread   (memread),
    .memwrite  (memwrite),
    .addr      (addr),
    .wdata     (wdata),
    .mem_rdata (mem_rdata),
    .stall     (stall),
    .addr_err  (addr_err),
    .bus_err   (bus_err),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_ack   (bus_ack),
    .bus_rdata (bus_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h required %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk_exp(input logic aerr, input logic berr, input logic [31:0] rd,
                                  input int sn, input int rn, input logic we,
                                  input logic [31:0] ba, input logic [31:0] bw);
    exp_t e;
    e.is_aerr = aerr; e.is_berr = berr; e.rdata = rd;
    e.stall_n = sn;   e.req_n = rn;     e.we = we;
    e.baddr = ba;     e.bwdata = bw;
    return e;
  endfunction

  // Monitor: completion = bus_req falling (DONE cycle) or an addr_err pulse.
  initial begin
    int          stall_n;
    int          req_n;
    logic        prev_req;
    logic        prev_aerr;
    logic        prev_berr;
    logic        unstable;
    logic        cap_we;
    logic [31:0] cap_addr;
    logic [31:0] cap_wdata;
    exp_t        e;
    stall_n = 0; req_n = 0; prev_req = 1'b0; prev_aerr = 1'b0; prev_berr = 1'b0;
    unstable = 1'b0; cap_we = 1'b0; cap_addr = 32'h0; cap_wdata = 32'h0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        stall_n = 0; req_n = 0; prev_req = 1'b0; prev_aerr = 1'b0;
        prev_berr = 1'b0; unstable = 1'b0;
      end else begin
        if (prev_aerr) chk("addr_err_one_cycle", {31'd0, addr_err}, 32'd0);
        if (prev_berr) chk("bus_err_one_cycle", {31'd0, bus_err}, 32'd0);
        if (stall) stall_n++;
        if (bus_req) begin
          req_n++;
          if (!prev_req) begin
            cap_we = bus_we; cap_addr = bus_addr; cap_wdata = bus_wdata; unstable = 1'b0;
          end else if (bus_we !== cap_we || bus_addr !== cap_addr || bus_wdata !== cap_wdata) begin
            unstable = 1'b1;
          end
        end
        if ((prev_req && !bus_req) || addr_err) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_completion: got event required none at %0t", $time);
          end else begin
            e = exp_q.pop_front();
            chk("addr_err", {31'd0, addr_err}, {31'd0, e.is_aerr});
            chk("bus_err", {31'd0, bus_err}, {31'd0, e.is_berr});
            chk("mem_rdata", mem_rdata, e.rdata);
            chk("stall_cycles", stall_n, e.stall_n);
            chk("bus_req_cycles", req_n, e.req_n);
            if (e.req_n > 0) begin
              chk("bus_we", {31'd0, cap_we}, {31'd0, e.we});
              chk("bus_addr", cap_addr, e.baddr);
              chk("bus_wdata", cap_wdata, e.bwdata);
              chk("bus_stable", {31'd0, unstable}, 32'd0);
            end
          end
          stall_n = 0; req_n = 0; unstable = 1'b0;
        end
        prev_req = bus_req; prev_aerr = addr_err; prev_berr = bus_err;
      end
    end
  end

  // ack_at: REQ cycle (1-based) carrying bus_ack; 0 means never acknowledge.
  task automatic do_access(input logic rd, input logic wr, input logic [31:0] a,
                           input logic [31:0] wd, input int ack_at,
                           input logic [31:0] rdv, input exp_t e);
    int n;
    exp_q.push_back(e);
    memread = rd; memwrite = wr; addr = a; wdata = wd;
    @(posedge clk); #1;
    if (e.is_aerr) begin
      memread = 1'b0; memwrite = 1'b0;
      @(posedge clk); #1;
    end else begin
      n = 0;
      while (bus_req && n < 20) begin
        if (n + 1 == ack_at) begin
          bus_ack = 1'b1; bus_rdata = rdv;
        end
        @(posedge clk); #1;
        bus_ack = 1'b0; bus_rdata = 32'hBAD0_BAD0;
        n++;
      end
      if (n >= 20) begin
        n_checks++;
        n_errors++;
        $display("FAIL req_bound: got bus_req still high after %0d cycles required completion", n);
      end
      @(posedge clk); #1;
      memread = 1'b0; memwrite = 1'b0;
    end
  endtask

  initial begin
    n_checks = 0; n_errors = 0;
    rst = 1'b0; memread = 1'b0; memwrite = 1'b0; addr = 32'h0; wdata = 32'h0;
    bus_ack = 1'b0; bus_rdata = 32'hBAD0_BAD0;
    #3;
    chk("rst_bus_req", {31'd0, bus_req}, 32'd0);
    chk("rst_bus_addr", bus_addr, 32'h0);
    chk("rst_mem_rdata", mem_rdata, 32'h0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    chk("idle_stall", {31'd0, stall}, 32'd0);

    // aligned load, zero wait
    do_access(1'b1, 1'b0, 32'h0000_0010, 32'h0000_0000, 1, 32'hCAFE_F00D,
              mk_exp(1'b0, 1'b0, 32'hCAFE_F00D, 2, 1, 1'b0, 32'h0000_0010, 32'h0000_0000));
    // aligned store, ack on 4th REQ cycle (also the terminal-count cycle)
    do_access(1'b0, 1'b1, 32'h0000_0020, 32'h1234_5678, 4, 32'hDEAD_BEEF,
              mk_exp(1'b0, 1'b0, 32'hCAFE_F00D, 5, 4, 1'b1, 32'h0000_0020, 32'h1234_5678));
    // misaligned load
    do_access(1'b1, 1'b0, 32'h0000_0013, 32'h0000_0000, 0, 32'h0,
              mk_exp(1'b1, 1'b0, 32'h0000_0000, 0, 0, 1'b0, 32'h0, 32'h0));
    // load, one wait state
    do_access(1'b1, 1'b0, 32'h0000_0008, 32'h0000_0077, 2, 32'h55AA_33CC,
              mk_exp(1'b0, 1'b0, 32'h55AA_33CC, 3, 2, 1'b0, 32'h0000_0008, 32'h0000_0077));
    // timeout
    do_access(1'b1, 1'b0, 32'h0000_0030, 32'h0000_0000, 0, 32'h0,
              mk_exp(1'b0, 1'b1, 32'h0000_0000, 5, 4, 1'b0, 32'h0000_0030, 32'h0000_0000));
    // memread & memwrite together behaves as a store
    do_access(1'b1, 1'b1, 32'h0000_0040, 32'hA5A5_A5A5, 1, 32'h9999_9999,
              mk_exp(1'b0, 1'b0, 32'h0000_0000, 2, 1, 1'b1, 32'h0000_0040, 32'hA5A5_A5A5));
    // back-to-back loads
    do_access(1'b1, 1'b0, 32'h0000_0000, 32'h0000_0000, 1, 32'h1111_1111,
              mk_exp(1'b0, 1'b0, 32'h1111_1111, 2, 1, 1'b0, 32'h0000_0000, 32'h0000_0000));
    do_access(1'b1, 1'b0, 32'h0000_0004, 32'h0000_0000, 1, 32'h2222_2222,
              mk_exp(1'b0, 1'b0, 32'h2222_2222, 2, 1, 1'b0, 32'h0000_0004, 32'h0000_0000));

    // reset in the middle of a request
    memread = 1'b1; addr = 32'h0000_0050; wdata = 32'h0000_0066;
    @(posedge clk); #1;
    chk("midreq_bus_req_up", {31'd0, bus_req}, 32'd1);
    @(posedge clk); #1;
    memread = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("midreq_bus_req_drop", {31'd0, bus_req}, 32'd0);
    chk("midreq_bus_addr", bus_addr, 32'h0);
    chk("midreq_bus_wdata", bus_wdata, 32'h0);
    chk("midreq_mem_rdata", mem_rdata, 32'h0);
    chk("midreq_stall", {31'd0, stall}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("post_rst_stall", {31'd0, stall}, 32'd0);
    chk("post_rst_bus_req", {31'd0, bus_req}, 32'd0);

    repeat (3) @(posedge clk);
    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
